// File: rtl/ifu_prefetch_if.sv
// ---------------------------------------------------------------------------
// ifu_prefetch_if
//   Bundles the prefetch unit's ICCM read port, the redirect inputs from exe
//   and dec, and the instruction handshake towards dec.
//   master : the prefetch unit (drives ICCM requests and the queue head)
//   slave  : the environment (ICCM, exe, dec)
//   Signals
//     iccm_rd_en / iccm_rd_addr   request, byte address with bits[1:0]=0
//     iccm_rd_data                read data, one cycle after the request
//     flush_from_exe/_addr_exe    redirect from exe (wins over dec)
//     flush_from_dec/_addr_dec    redirect from dec
//     instr_valid_o/instr_ready_i head handshake
//     instr_o / instr_pc_o        head instruction word and its address
//     level_o                     queue occupancy
// ---------------------------------------------------------------------------
interface ifu_prefetch_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic            iccm_rd_en;
  logic [XLEN-1:0] iccm_rd_addr;
  logic [XLEN-1:0] iccm_rd_data;
  logic            flush_from_exe;
  logic [XLEN-1:0] flush_addr_exe;
  logic            flush_from_dec;
  logic [XLEN-1:0] flush_addr_dec;
  logic            instr_valid_o;
  logic            instr_ready_i;
  logic [XLEN-1:0] instr_o;
  logic [XLEN-1:0] instr_pc_o;
  logic [LW-1:0]   level_o;

  modport master (
    output iccm_rd_en, iccm_rd_addr,
    input  iccm_rd_data,
    input  flush_from_exe, flush_addr_exe, flush_from_dec, flush_addr_dec,
    output instr_valid_o,
    input  instr_ready_i,
    output instr_o, instr_pc_o, level_o
  );

  modport slave (
    input  iccm_rd_en, iccm_rd_addr,
    output iccm_rd_data,
    output flush_from_exe, flush_addr_exe, flush_from_dec, flush_addr_dec,
    input  instr_valid_o,
    output instr_ready_i,
    input  instr_o, instr_pc_o, level_o
  );
endinterface

// File: rtl/ifu_prefetch.sv
// ---------------------------------------------------------------------------
// ifu_prefetch
//   Streams instruction words from ICCM into a DEPTH-entry prefetch queue and
//   presents the head to dec over valid/ready. Redirects from exe/dec (exe
//   wins) restart fetch at the target and throw away queued and in-flight
//   words.
//   Ports
//     clk        rising-edge clock
//     rst        synchronous reset, active high
//     fetch_en_i 1 = issue new ICCM requests, 0 = pause (queue still drains)
//     bus        ifu_prefetch_if.master (ICCM port, redirects, dec handshake)
// ---------------------------------------------------------------------------
module ifu_prefetch #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           fetch_en_i,
  ifu_prefetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_STALL} state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;       // next address to request
  logic [XLEN-1:0] req_pc_q;   // address of the request now in flight
  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   cnt_q;
  logic            infl_q;     // response arrives this cycle
  logic            drop_q;     // mask the response slot following a flush

  logic            flush_any;
  logic [XLEN-1:0] tgt_raw, flush_tgt;
  logic [CW:0]     occ, occ_nx;
  logic [CW-1:0]   cnt_nx;
  logic            req, valid, push, pop;

  always_comb begin
    flush_any = bus.flush_from_exe | bus.flush_from_dec;
    tgt_raw   = bus.flush_from_exe ? bus.flush_addr_exe : bus.flush_addr_dec;
    flush_tgt = tgt_raw & ~XLEN'(3);

    // Credit: queued words plus the outstanding response must fit the queue,
    // so a response always has a slot when it lands.
    occ   = {1'b0, cnt_q} + (CW+1)'(infl_q);
    req   = (state_q == S_FETCH) & fetch_en_i & ~flush_any
            & (occ < (CW+1)'(DEPTH));
    valid = (cnt_q != '0);

    // A flush empties the queue, so neither the landing response nor a
    // concurrent pop may touch it.
    push   = infl_q & ~drop_q & ~flush_any;
    pop    = valid & bus.instr_ready_i & ~flush_any;
    cnt_nx = cnt_q + CW'(push) - CW'(pop);
    occ_nx = {1'b0, cnt_nx} + (CW+1)'(req);
  end

  assign bus.iccm_rd_en    = req;
  assign bus.iccm_rd_addr  = pc_q;
  assign bus.instr_valid_o = valid;
  assign bus.instr_o       = mem_q[rd_q].instr;
  assign bus.instr_pc_o    = mem_q[rd_q].pc;
  assign bus.level_o       = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      infl_q   <= 1'b0;
      drop_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_any) begin
      state_q <= S_FETCH;
      pc_q    <= flush_tgt;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      infl_q  <= 1'b0;
      drop_q  <= infl_q;
    end else begin
      infl_q <= req;
      drop_q <= 1'b0;
      if (req) begin
        pc_q     <= pc_q + XLEN'(4);
        req_pc_q <= pc_q;
      end
      if (push) begin
        mem_q[wr_q] <= '{pc: req_pc_q, instr: bus.iccm_rd_data};
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_nx;
      // STALL tracks "no credit next cycle" so fetch resumes the very cycle
      // a slot frees up.
      case (state_q)
        S_BOOT:  state_q <= S_FETCH;
        default: state_q <= (occ_nx < (CW+1)'(DEPTH)) ? S_FETCH : S_STALL;
      endcase
    end
  end
endmodule

// File: tb/tb_ifu_prefetch.sv
// ---------------------------------------------------------------------------
// tb_ifu_prefetch
//   Directed bench for ifu_prefetch. ICCM model returns addr ^ 32'hA5A5_0000
//   one cycle after each request. Inputs change on the falling edge; outputs
//   are sampled 1ns later, so each sample point belongs to one cycle.
// ---------------------------------------------------------------------------
module tb_ifu_prefetch;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] K     = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fetch_en = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_req;

  ifu_prefetch_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  ifu_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_en_i (fetch_en),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    bus.iccm_rd_data <= bus.iccm_rd_en ? (bus.iccm_rd_addr ^ K) : 32'hDEAD_BEEF;

  always @(negedge clk)
    if (!rst) assert (bus.level_o <= 3'd4) else $error("queue overflow level=%0d", bus.level_o);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic en, input logic rdy, input logic fe, input logic [31:0] ae,
                     input logic fd, input logic [31:0] ad);
    @(negedge clk);
    fetch_en           = en;
    bus.instr_ready_i  = rdy;
    bus.flush_from_exe = fe;
    bus.flush_addr_exe = ae;
    bus.flush_from_dec = fd;
    bus.flush_addr_dec = ad;
    #1;
  endtask

  task automatic go(input logic rdy);
    drv(1'b1, rdy, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Leaves the bench at the sample point of cycle 0 (BOOT).
  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    repeat (2) go(rdy);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    bus.instr_ready_i  = 1'b0;
    bus.flush_from_exe = 1'b0;
    bus.flush_addr_exe = '0;
    bus.flush_from_dec = 1'b0;
    bus.flush_addr_dec = '0;

    // reset state
    rst = 1'b1;
    go(1'b1); go(1'b1);
    chk("rst_level", bus.level_o, 0);
    chk("rst_valid", bus.instr_valid_o, 0);
    chk("rst_rden",  bus.iccm_rd_en, 0);
    chk("rst_addr",  bus.iccm_rd_addr, 0);
    chk("rst_instr", bus.instr_o, 0);
    chk("rst_pc",    bus.instr_pc_o, 0);

    // boot and streaming
    do_reset(1'b1);
    chk("boot_c0_rden", bus.iccm_rd_en, 0);
    go(1'b1);
    chk("boot_c1_rden", bus.iccm_rd_en, 1);
    chk("boot_c1_addr", bus.iccm_rd_addr, 32'h0);
    chk("boot_c1_valid", bus.instr_valid_o, 0);
    go(1'b1);
    chk("boot_c2_addr", bus.iccm_rd_addr, 32'h4);
    chk("boot_c2_valid", bus.instr_valid_o, 0);
    for (int i = 0; i < 5; i++) begin
      go(1'b1);
      chk("boot_valid", bus.instr_valid_o, 1);
      chk("boot_pc", bus.instr_pc_o, 32'(4 * i));
      chk("boot_instr", bus.instr_o, 32'(4 * i) ^ K);
      chk("boot_level", bus.level_o, 1);
    end

    // backpressure
    do_reset(1'b0);
    n_req = 0;
    for (int i = 1; i <= 10; i++) begin
      go(1'b0);
      if (bus.iccm_rd_en) n_req++;
    end
    chk("bp_nreq", n_req, 4);
    chk("bp_level", bus.level_o, 4);
    chk("bp_rden", bus.iccm_rd_en, 0);
    chk("bp_valid", bus.instr_valid_o, 1);
    for (int i = 0; i < 6; i++) begin
      go(1'b1);
      chk("bp_drain_valid", bus.instr_valid_o, 1);
      chk("bp_drain_pc", bus.instr_pc_o, 32'(4 * i));
    end

    // exe flush with a request in flight
    do_reset(1'b1);
    go(1'b1); go(1'b1);
    drv(1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
    chk("fx_c3_rden", bus.iccm_rd_en, 0);
    chk("fx_c3_pc", bus.instr_pc_o, 32'h0);
    go(1'b1);
    chk("fx_c4_valid", bus.instr_valid_o, 0);
    chk("fx_c4_rden", bus.iccm_rd_en, 1);
    chk("fx_c4_addr", bus.iccm_rd_addr, 32'h100);
    go(1'b1);
    chk("fx_c5_valid", bus.instr_valid_o, 0);
    chk("fx_c5_addr", bus.iccm_rd_addr, 32'h104);
    go(1'b1);
    chk("fx_c6_valid", bus.instr_valid_o, 1);
    chk("fx_c6_pc", bus.instr_pc_o, 32'h100);
    chk("fx_c6_instr", bus.instr_o, 32'h100 ^ K);
    go(1'b1);
    chk("fx_c7_pc", bus.instr_pc_o, 32'h104);

    // simultaneous exe/dec flush, then misaligned dec target
    do_reset(1'b1);
    repeat (3) go(1'b1);
    drv(1'b1, 1'b1, 1'b1, 32'h200, 1'b1, 32'h300);
    go(1'b1);
    chk("fsim_addr", bus.iccm_rd_addr, 32'h200);
    chk("fsim_rden", bus.iccm_rd_en, 1);
    go(1'b1); go(1'b1);
    chk("fsim_pc", bus.instr_pc_o, 32'h200);
    chk("fsim_instr", bus.instr_o, 32'h200 ^ K);
    drv(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h203);
    chk("fmis_flush_rden", bus.iccm_rd_en, 0);
    go(1'b1);
    chk("fmis_addr", bus.iccm_rd_addr, 32'h200);
    chk("fmis_valid0", bus.instr_valid_o, 0);
    go(1'b1);
    chk("fmis_valid1", bus.instr_valid_o, 0);
    go(1'b1);
    chk("fmis_valid2", bus.instr_valid_o, 1);
    chk("fmis_pc", bus.instr_pc_o, 32'h200);

    // fetch pause mid-stream
    do_reset(1'b1);
    repeat (4) go(1'b1);
    drv(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("fe_c5_rden", bus.iccm_rd_en, 0);
    chk("fe_c5_pc", bus.instr_pc_o, 32'h8);
    drv(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("fe_c6_pc", bus.instr_pc_o, 32'hC);
    chk("fe_c6_level", bus.level_o, 1);
    drv(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("fe_c7_valid", bus.instr_valid_o, 0);
    chk("fe_c7_level", bus.level_o, 0);
    drv(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    drv(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("fe_c9_rden", bus.iccm_rd_en, 0);
    chk("fe_c9_level", bus.level_o, 0);
    go(1'b1);
    chk("fe_c10_rden", bus.iccm_rd_en, 1);
    chk("fe_c10_addr", bus.iccm_rd_addr, 32'h10);
    go(1'b1); go(1'b1);
    chk("fe_c12_pc", bus.instr_pc_o, 32'h10);

    // reset mid-operation with a loaded queue and a response in flight
    do_reset(1'b0);
    repeat (5) go(1'b0);
    chk("rm_c5_level", bus.level_o, 3);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rm_level", bus.level_o, 0);
    chk("rm_valid", bus.instr_valid_o, 0);
    chk("rm_rden", bus.iccm_rd_en, 0);
    chk("rm_addr", bus.iccm_rd_addr, 32'h0);
    chk("rm_instr", bus.instr_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.instr_ready_i = 1'b1;
    #1;
    go(1'b1);
    chk("rm_restart_addr", bus.iccm_rd_addr, 32'h0);
    chk("rm_restart_rden", bus.iccm_rd_en, 1);
    go(1'b1); go(1'b1);
    chk("rm_restart_pc", bus.instr_pc_o, 32'h0);
    chk("rm_restart_instr", bus.instr_o, K);

    // pc wrap at the top of the address space
    do_reset(1'b1);
    go(1'b1);
    drv(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    go(1'b1);
    chk("wr_addr0", bus.iccm_rd_addr, 32'hFFFF_FFFC);
    chk("wr_valid0", bus.instr_valid_o, 0);
    go(1'b1);
    chk("wr_addr1", bus.iccm_rd_addr, 32'h0);
    chk("wr_rden1", bus.iccm_rd_en, 1);
    go(1'b1);
    chk("wr_pc0", bus.instr_pc_o, 32'hFFFF_FFFC);
    chk("wr_instr0", bus.instr_o, 32'h5A5A_FFFC);
    go(1'b1);
    chk("wr_pc1", bus.instr_pc_o, 32'h0);
    chk("wr_instr1", bus.instr_o, 32'hA5A5_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
